// File: rtl/serial_word_collector_if.sv
// Bundles the serial input, sync/ovf controls and the word output handshake.
// No logic of its own; pure wiring between producer, collector and consumer.
// Backpressure travels on out_rdy from the consumer side (master) to the collector.
interface serial_word_collector_if #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic             sin;
  logic             sin_vld;
  logic             sync;
  logic [WIDTH-1:0] out_data;
  logic             out_vld;
  logic             out_rdy;
  logic [LW-1:0]    level;
  logic             ovf;
  logic             ovf_clr;

  // Side that feeds bits and consumes words.
  modport master (
    output sin, sin_vld, sync, out_rdy, ovf_clr,
    input  out_data, out_vld, level, ovf
  );

  // The collector itself.
  modport slave (
    input  sin, sin_vld, sync, out_rdy, ovf_clr,
    output out_data, out_vld, level, ovf
  );
endinterface

// File: rtl/serial_word_collector.sv
// Reassembles MSB-first serial bits into WIDTH-bit words, queued in a FWFT FIFO.
// Latency: word visible on out_vld/out_data the cycle after its last bit is sampled.
// Backpressure: out_rdy low holds the head word; a word completed while full is dropped and flags ovf.
module serial_word_collector #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  serial_word_collector_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [WIDTH-1:0] word;
  logic             word_done;
  logic             full;
  logic             out_vld;
  logic             pop;
  logic             push;
  logic             drop;

  // Completed word includes the bit arriving this cycle; sync suppresses completion.
  assign word      = {acc_q[WIDTH-2:0], bus.sin};
  assign word_done = bus.sin_vld & ~bus.sync & (cnt_q == CW'(WIDTH - 1));
  assign full      = (level_q == LW'(DEPTH));
  assign out_vld   = (level_q != '0);
  assign pop       = out_vld & bus.out_rdy;
  // A pop in the same cycle frees the slot a full FIFO needs for the new word.
  assign push      = word_done & (~full | pop);
  assign drop      = word_done & full & ~pop;

  // Accumulator next state: sync restarts alignment, optionally with this cycle's bit as bit 0.
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (bus.sync) begin
      if (bus.sin_vld) begin
        acc_d = {{(WIDTH-1){1'b0}}, bus.sin};
        cnt_d = CW'(1);
      end else begin
        acc_d = '0;
        cnt_d = '0;
      end
    end else if (bus.sin_vld) begin
      acc_d = word;
      cnt_d = word_done ? '0 : cnt_q + CW'(1);
    end
  end

  // FIFO pointer, occupancy and sticky overflow next state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    // A new drop outranks a coincident clear.
    if (drop)             ovf_d = 1'b1;
    else if (bus.ovf_clr) ovf_d = 1'b0;
  end

  // Control state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q    <= '0;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage array; contents are only observable through level, so no reset is needed.
  always_ff @(posedge clk) begin
    if (rst_n && push) mem_q[wr_ptr_q] <= word;
  end

  assign bus.out_vld  = out_vld;
  assign bus.out_data = out_vld ? mem_q[rd_ptr_q] : '0;
  assign bus.level    = level_q;
  assign bus.ovf      = ovf_q;
endmodule

// File: tb/tb_serial_word_collector.sv
// Directed bench for serial_word_collector (WIDTH=4, DEPTH=4).
// Inputs change 1ns after the rising edge; outputs are sampled at that same point.
// Expected values are hand-computed constants.
module tb_serial_word_collector;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  serial_word_collector_if #(.WIDTH(4), .DEPTH(4)) intf ();

  serial_word_collector #(.WIDTH(4), .DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (intf.slave)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    intf.sin     = b;
    intf.sin_vld = 1'b1;
    step();
    intf.sin_vld = 1'b0;
    intf.sin     = 1'b0;
  endtask

  task automatic send_word(input logic [3:0] w);
    for (int i = 3; i >= 0; i--) send_bit(w[i]);
  endtask

  initial begin
    rst_n        = 1'b0;
    intf.sin     = 1'b1;
    intf.sin_vld = 1'b1;
    intf.sync    = 1'b0;
    intf.out_rdy = 1'b1;
    intf.ovf_clr = 1'b0;

    // Reset held two cycles with activity on sin_vld and a toggling sync.
    step();
    chk("rst_vld0", {31'd0, intf.out_vld}, 32'd0);
    chk("rst_lvl0", {29'd0, intf.level}, 32'd0);
    intf.sync = 1'b1;
    step();
    chk("rst_vld1", {31'd0, intf.out_vld}, 32'd0);
    chk("rst_lvl1", {29'd0, intf.level}, 32'd0);
    chk("rst_ovf",  {31'd0, intf.ovf}, 32'd0);
    chk("rst_data", {28'd0, intf.out_data}, 32'd0);
    rst_n        = 1'b1;
    intf.sync    = 1'b0;
    intf.sin_vld = 1'b0;
    intf.sin     = 1'b0;

    // Back-to-back bits 1,0,1,1 -> 4'hB for one cycle.
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    chk("b2b_pre_vld", {31'd0, intf.out_vld}, 32'd0);
    send_bit(1'b1);
    chk("b2b_vld",  {31'd0, intf.out_vld}, 32'd1);
    chk("b2b_data", {28'd0, intf.out_data}, 32'hB);
    chk("b2b_lvl",  {29'd0, intf.level}, 32'd1);
    step();
    chk("b2b_vld_after", {31'd0, intf.out_vld}, 32'd0);
    chk("b2b_lvl_after", {29'd0, intf.level}, 32'd0);

    // Gapped bits 0,1,1,0 with two idle cycles between each -> 4'h6.
    send_bit(1'b0); step(); step();
    send_bit(1'b1); step(); step();
    send_bit(1'b1); step(); step();
    chk("gap_pre_vld", {31'd0, intf.out_vld}, 32'd0);
    send_bit(1'b0);
    chk("gap_vld",  {31'd0, intf.out_vld}, 32'd1);
    chk("gap_data", {28'd0, intf.out_data}, 32'h6);
    step();
    chk("gap_lvl_after", {29'd0, intf.level}, 32'd0);

    // Sync realignment: 1,1 discarded; sync with bit 0, then 0,1,1 -> 4'h3.
    send_bit(1'b1);
    send_bit(1'b1);
    intf.sync = 1'b1;
    send_bit(1'b0);
    intf.sync = 1'b0;
    chk("sync_no_push", {31'd0, intf.out_vld}, 32'd0);
    send_bit(1'b0);
    send_bit(1'b1);
    chk("sync_pre_vld", {31'd0, intf.out_vld}, 32'd0);
    send_bit(1'b1);
    chk("sync_vld",  {31'd0, intf.out_vld}, 32'd1);
    chk("sync_data", {28'd0, intf.out_data}, 32'h3);
    step();
    chk("sync_lvl_after", {29'd0, intf.level}, 32'd0);

    // Overflow: A,B,C,D stored, E dropped while stalled.
    intf.out_rdy = 1'b0;
    send_word(4'hA);
    send_word(4'hB);
    send_word(4'hC);
    chk("ovf_lvl3", {29'd0, intf.level}, 32'd3);
    send_word(4'hD);
    chk("ovf_lvl4", {29'd0, intf.level}, 32'd4);
    chk("ovf_pre",  {31'd0, intf.ovf}, 32'd0);
    send_word(4'hE);
    chk("ovf_lvl_after_e", {29'd0, intf.level}, 32'd4);
    chk("ovf_set",         {31'd0, intf.ovf}, 32'd1);
    chk("ovf_head_stable", {28'd0, intf.out_data}, 32'hA);
    intf.out_rdy = 1'b1;
    chk("drain_a", {28'd0, intf.out_data}, 32'hA);
    step();
    chk("drain_b", {28'd0, intf.out_data}, 32'hB);
    step();
    chk("drain_c", {28'd0, intf.out_data}, 32'hC);
    step();
    chk("drain_d", {28'd0, intf.out_data}, 32'hD);
    step();
    chk("drain_empty",  {31'd0, intf.out_vld}, 32'd0);
    chk("drain_data0",  {28'd0, intf.out_data}, 32'd0);
    chk("ovf_sticky",   {31'd0, intf.ovf}, 32'd1);
    intf.ovf_clr = 1'b1;
    step();
    intf.ovf_clr = 1'b0;
    chk("ovf_cleared", {31'd0, intf.ovf}, 32'd0);

    // ovf_clr coincident with a new overflow: set wins.
    intf.out_rdy = 1'b0;
    send_word(4'h1);
    send_word(4'h2);
    send_word(4'h3);
    send_word(4'h4);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    intf.ovf_clr = 1'b1;
    send_bit(1'b1);
    intf.ovf_clr = 1'b0;
    chk("ovf_clr_vs_set", {31'd0, intf.ovf}, 32'd1);
    chk("ovf_head_kept",  {28'd0, intf.out_data}, 32'h1);
    intf.out_rdy = 1'b1;
    step(); step(); step(); step();
    chk("drain2_lvl", {29'd0, intf.level}, 32'd0);
    intf.ovf_clr = 1'b1;
    step();
    intf.ovf_clr = 1'b0;
    chk("ovf_cleared2", {31'd0, intf.ovf}, 32'd0);

    // Full FIFO with a pop on the completing cycle: push accepted.
    intf.out_rdy = 1'b0;
    send_word(4'h9);
    send_word(4'h8);
    send_word(4'h7);
    send_word(4'h6);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    intf.out_rdy = 1'b1;
    send_bit(1'b1);
    chk("fullpop_lvl",  {29'd0, intf.level}, 32'd4);
    chk("fullpop_ovf",  {31'd0, intf.ovf}, 32'd0);
    chk("fullpop_head", {28'd0, intf.out_data}, 32'h8);
    step();
    chk("fullpop_7", {28'd0, intf.out_data}, 32'h7);
    step();
    chk("fullpop_6", {28'd0, intf.out_data}, 32'h6);
    step();
    chk("fullpop_5", {28'd0, intf.out_data}, 32'h5);
    step();
    chk("fullpop_empty", {31'd0, intf.out_vld}, 32'd0);

    // Reset mid-word with a non-empty FIFO discards everything.
    intf.out_rdy = 1'b0;
    send_word(4'hC);
    send_bit(1'b1);
    send_bit(1'b1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("midrst_lvl", {29'd0, intf.level}, 32'd0);
    chk("midrst_vld", {31'd0, intf.out_vld}, 32'd0);
    intf.out_rdy = 1'b1;
    send_word(4'h5);
    chk("midrst_align_vld",  {31'd0, intf.out_vld}, 32'd1);
    chk("midrst_align_data", {28'd0, intf.out_data}, 32'h5);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
